// File: rtl/axi4_lite_master_core.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI4-Lite transaction out,
// one response pulse back. Write address and write data channels handshake independently.
module axi4_lite_master_core #(
    parameter int ID = 1,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [DW/8-1:0]   cmd_wstrb,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DW-1:0]     rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [7:0]        rsp_id,
    output logic [AW-1:0]     m_awaddr,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [AW-1:0]     m_araddr,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DW-1:0]     m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]       state_reg;
    logic             awvalid_reg;
    logic             wvalid_reg;
    logic             bready_reg;
    logic             arvalid_reg;
    logic             rready_reg;
    logic             rsp_valid_reg;
    logic             write_reg;
    logic             aw_done_reg;
    logic             w_done_reg;
    logic [AW-1:0]    addr_reg;
    logic [DW-1:0]    wdata_reg;
    logic [DW/8-1:0]  wstrb_reg;
    logic [DW-1:0]    rdata_reg;
    logic [1:0]       resp_reg;

    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_hs  = awvalid_reg & m_awready;
    assign w_hs   = wvalid_reg & m_wready;
    // A channel counts as finished if it completed earlier or completes on this edge.
    assign aw_fin = aw_done_reg | aw_hs;
    assign w_fin  = w_done_reg | w_hs;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= S_IDLE;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            write_reg     <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rdata_reg     <= '0;
            resp_reg      <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        write_reg   <= cmd_write;
                        addr_reg    <= cmd_addr;
                        wdata_reg   <= cmd_wdata;
                        wstrb_reg   <= cmd_wstrb;
                        rdata_reg   <= '0;
                        resp_reg    <= '0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        if (cmd_write) begin
                            state_reg   <= S_WRITE;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= S_READ;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state_reg  <= S_WRESP;
                        bready_reg <= 1'b1;
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        resp_reg      <= m_bresp;
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end
                end
                S_READ: begin
                    if (m_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        rdata_reg     <= m_rdata;
                        resp_reg      <= m_rresp;
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = aresetn && (state_reg == S_IDLE);

    assign rsp_valid = rsp_valid_reg;
    assign rsp_write = write_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_resp  = resp_reg;
    assign rsp_id    = 8'(ID);

    assign m_awaddr  = addr_reg;
    assign m_awcache = 4'b0011;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = wstrb_reg;
    assign m_wvalid  = wvalid_reg;
    assign m_bready  = bready_reg;
    assign m_araddr  = addr_reg;
    assign m_arcache = 4'b0011;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arvalid_reg;
    assign m_rready  = rready_reg;

endmodule

// File: tb/tb_axi4_lite_master_core.sv
// Directed bench for axi4_lite_master_core: a per-cycle slave model with programmable
// channel delays, a table of single transactions, and hand sequences for the corner cases.
module tb_axi4_lite_master_core;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_id;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    axi4_lite_master_core #(.ID(1), .AW(32), .DW(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .m_awaddr(m_awaddr), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          a_dly;
        int          w_dly;
        int          resp_dly;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int rsp_cnt  = 0;
    int acc_cyc  = 0;
    int rsp_cyc  = 0;
    int stab_err = 0;
    int proto_err = 0;
    int pulse_err = 0;
    int ovl_err  = 0;

    int cfg_a_dly, cfg_w_dly, cfg_resp_dly;
    logic [1:0]  cfg_sresp;
    logic [31:0] cfg_srdata;

    bit aw_got, w_got, ar_got;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
    int aw_hs_cyc, w_hs_cyc;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    logic prev_cmd_ready, prev_awvalid, prev_wvalid, prev_arvalid;
    logic prev_bready, prev_rready, prev_rsp_valid;
    logic        cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;

    logic        rq_w [$];
    logic [31:0] rq_d [$];
    logic [1:0]  rq_r [$];
    logic [7:0]  last_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic slave_clear();
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    endtask

    // One clock of bench activity: slave model, monitor and protocol checks, all at negedge.
    task automatic cycle();
        @(negedge aclk);
        cyc++;
        if (!aresetn) begin
            slave_clear();
            acc_cnt = rsp_cnt;
            prev_cmd_ready = 0; prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0;
            prev_bready = 0; prev_rready = 0; prev_rsp_valid = 0;
            return;
        end
        if (cmd_valid && prev_cmd_ready) begin
            if (acc_cnt != rsp_cnt) ovl_err++;
            acc_cnt++;
            acc_cyc   = cyc;
            cur_write = cmd_write;
            cur_addr  = cmd_addr;
            cur_wdata = cmd_wdata;
            cur_wstrb = cmd_wstrb;
        end
        if (m_awready && prev_awvalid) begin
            aw_got = 1; aw_hs_cnt++; aw_hs_cyc = cyc; cap_awaddr = m_awaddr; m_awready = 0;
            if (m_awvalid) proto_err++;
        end else if (m_awvalid && !aw_got && !m_awready) begin
            if (aw_cnt == cfg_a_dly) m_awready = 1; else aw_cnt++;
        end
        if (m_wready && prev_wvalid) begin
            w_got = 1; w_hs_cnt++; w_hs_cyc = cyc; cap_wdata = m_wdata; cap_wstrb = m_wstrb;
            m_wready = 0;
            if (m_wvalid) proto_err++;
        end else if (m_wvalid && !w_got && !m_wready) begin
            if (w_cnt == cfg_w_dly) m_wready = 1; else w_cnt++;
        end
        if (m_arready && prev_arvalid) begin
            ar_got = 1; ar_hs_cnt++; cap_araddr = m_araddr; m_arready = 0;
            if (m_arvalid) proto_err++;
        end else if (m_arvalid && !ar_got && !m_arready) begin
            if (ar_cnt == cfg_a_dly) m_arready = 1; else ar_cnt++;
        end
        if (m_bvalid && prev_bready) begin
            m_bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else if (aw_got && w_got && !m_bvalid) begin
            if (b_cnt == cfg_resp_dly) begin m_bvalid = 1; m_bresp = cfg_sresp; end
            else b_cnt++;
        end
        if (m_rvalid && prev_rready) begin
            m_rvalid = 0; m_rdata = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
        end else if (ar_got && !m_rvalid) begin
            if (r_cnt == cfg_resp_dly) begin
                m_rvalid = 1; m_rdata = cfg_srdata; m_rresp = cfg_sresp;
            end else r_cnt++;
        end
        if (rsp_valid) begin
            if (prev_rsp_valid) pulse_err++;
            rq_w.push_back(rsp_write);
            rq_d.push_back(rsp_rdata);
            rq_r.push_back(rsp_resp);
            last_id = rsp_id;
            rsp_cnt++;
            rsp_cyc = cyc;
        end
        if (m_awvalid && m_awaddr !== cur_addr) stab_err++;
        if (m_wvalid && (m_wdata !== cur_wdata || m_wstrb !== cur_wstrb)) stab_err++;
        if (m_arvalid && m_araddr !== cur_addr) stab_err++;
        if (cmd_ready && (m_awvalid || m_wvalid || m_bready || m_arvalid || m_rready)) ovl_err++;
        prev_cmd_ready = cmd_ready;
        prev_awvalid   = m_awvalid;
        prev_wvalid    = m_wvalid;
        prev_arvalid   = m_arvalid;
        prev_bready    = m_bready;
        prev_rready    = m_rready;
        prev_rsp_valid = rsp_valid;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output bit ok);
        int base;
        base = acc_cnt;
        ok = 0;
        set_cmd(w, a, d, s);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (acc_cnt != base) begin ok = 1; break; end
        end
        cmd_valid = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int rsp_base, aw_base, w_base, ar_base;
        rsp_base = rsp_cnt; aw_base = aw_hs_cnt; w_base = w_hs_cnt; ar_base = ar_hs_cnt;
        cfg_a_dly = v.a_dly; cfg_w_dly = v.w_dly; cfg_resp_dly = v.resp_dly;
        cfg_sresp = v.sresp; cfg_srdata = v.srdata;
        issue(v.write, v.addr, v.wdata, v.wstrb, ok);
        check($sformatf("v%0d_accept", idx), 32'(ok), 1);
        for (int k = 0; k < 60 && rsp_cnt == rsp_base; k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        check($sformatf("v%0d_rsp_count", idx), rsp_cnt - rsp_base, 1);
        if (rsp_cnt > rsp_base) begin
            $display("txn v%0d: write=%0d addr=%08h rsp_write=%0d rsp_rdata=%08h rsp_resp=%0d",
                     idx, v.write, v.addr, rq_w[rsp_base], rq_d[rsp_base], rq_r[rsp_base]);
            check($sformatf("v%0d_rsp_write", idx), 32'(rq_w[rsp_base]), 32'(v.write));
            check($sformatf("v%0d_rsp_rdata", idx), rq_d[rsp_base], v.exp_rdata);
            check($sformatf("v%0d_rsp_resp", idx), 32'(rq_r[rsp_base]), 32'(v.exp_resp));
            check($sformatf("v%0d_rsp_id", idx), 32'(last_id), 1);
            if (v.exp_lat >= 0)
                check($sformatf("v%0d_latency", idx), rsp_cyc - acc_cyc, v.exp_lat);
        end
        if (v.write) begin
            check($sformatf("v%0d_aw_beats", idx), aw_hs_cnt - aw_base, 1);
            check($sformatf("v%0d_w_beats", idx), w_hs_cnt - w_base, 1);
            check($sformatf("v%0d_awaddr", idx), cap_awaddr, v.addr);
            check($sformatf("v%0d_wdata", idx), cap_wdata, v.wdata);
            check($sformatf("v%0d_wstrb", idx), 32'(cap_wstrb), 32'(v.wstrb));
            check($sformatf("v%0d_aw_to_w", idx), w_hs_cyc - aw_hs_cyc, v.w_dly - v.a_dly);
        end else begin
            check($sformatf("v%0d_ar_beats", idx), ar_hs_cnt - ar_base, 1);
            check($sformatf("v%0d_araddr", idx), cap_araddr, v.addr);
        end
    endtask

    logic        seq_w [3];
    logic [31:0] seq_a [3];
    logic [31:0] seq_d [3];
    int          seq_acc [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k, rsp_base, acc_base;

        //          wr    addr           wdata          strb  a  w  rsp  sresp  srdata         exp_rdata      exp_resp lat
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,         32'h0,         2'b00,   2};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 0, 3, 1, 2'b00, 32'h0,         32'h0,         2'b00,   6};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2, 0, 2, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00,   6};
        vecs[3] = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'hC, 0, 0, 0, 2'b10, 32'h0,         32'h0,         2'b10,   2};
        vecs[4] = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b11,   2};
        vecs[5] = '{1'b1, 32'h0000_0038, 32'h0BAD_F00D, 4'h1, 2, 0, 0, 2'b01, 32'h0,         32'h0,         2'b01,   4};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1, 0, 3, 2'b00, 32'h8000_0001, 32'h8000_0001, 2'b00,   6};

        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        cfg_a_dly = 0; cfg_w_dly = 0; cfg_resp_dly = 0; cfg_sresp = 0; cfg_srdata = 0;
        cur_write = 0; cur_addr = 0; cur_wdata = 0; cur_wstrb = 0;
        slave_clear();
        for (int i = 0; i < 3; i++) cycle();

        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_valids", {26'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp_write", {29'd0, rsp_resp, rsp_write}, 0);
        check("const_cache", {24'd0, m_awcache, m_arcache}, 32'h33);
        check("const_prot", {26'd0, m_awprot, m_arprot}, 0);
        check("const_id", 32'(rsp_id), 1);

        aresetn = 1;
        cycle();
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Three back-to-back commands with cmd_valid never dropping between them.
        seq_w[0] = 1'b1; seq_a[0] = 32'h40; seq_d[0] = 32'h1111_1111;
        seq_w[1] = 1'b0; seq_a[1] = 32'h44; seq_d[1] = 32'h0;
        seq_w[2] = 1'b1; seq_a[2] = 32'h48; seq_d[2] = 32'h3333_3333;
        cfg_a_dly = 0; cfg_w_dly = 0; cfg_resp_dly = 0; cfg_sresp = 2'b00; cfg_srdata = 32'h2222_2222;
        rsp_base = rsp_cnt; acc_base = acc_cnt; k = 0;
        set_cmd(seq_w[0], seq_a[0], seq_d[0], 4'hF);
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (acc_cnt - acc_base > k) begin
                seq_acc[k] = cyc;
                k++;
                if (k < 3) set_cmd(seq_w[k], seq_a[k], seq_d[k], 4'hF);
                else cmd_valid = 0;
            end
            if (k >= 3 && rsp_cnt - rsp_base >= 3) break;
        end
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("seq_accepts", k, 3);
        check("seq_rsp_count", rsp_cnt - rsp_base, 3);
        if (k == 3) begin
            check("seq_gap01", seq_acc[1] - seq_acc[0], 4);
            check("seq_gap12", seq_acc[2] - seq_acc[1], 4);
        end
        if (rsp_cnt - rsp_base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                $display("txn seq%0d: write=%0d addr=%08h rsp_write=%0d rsp_rdata=%08h rsp_resp=%0d",
                         i, seq_w[i], seq_a[i], rq_w[rsp_base+i], rq_d[rsp_base+i], rq_r[rsp_base+i]);
                check($sformatf("seq%0d_rsp_write", i), 32'(rq_w[rsp_base+i]), 32'(seq_w[i]));
            end
            check("seq1_rsp_rdata", rq_d[rsp_base+1], 32'h2222_2222);
            check("seq2_rsp_rdata", rq_d[rsp_base+2], 32'h0);
        end

        // Reset while waiting for the write response.
        cfg_a_dly = 0; cfg_w_dly = 0; cfg_resp_dly = 20; cfg_sresp = 2'b00;
        issue(1'b1, 32'h50, 32'h5555_AAAA, 4'hF, ok);
        check("mid_accept", 32'(ok), 1);
        for (int n = 0; n < 20 && !m_bready; n++) cycle();
        check("mid_in_wresp", 32'(m_bready), 1);
        rsp_base = rsp_cnt;
        aresetn = 0;
        cycle();
        check("mid_rst_valids", {25'd0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid,
                                 m_rready, rsp_valid}, 0);
        check("mid_rst_rsp_fields", {29'd0, rsp_resp, rsp_write}, 0);
        aresetn = 1;
        for (int i = 0; i < 5; i++) cycle();
        check("mid_no_response", rsp_cnt - rsp_base, 0);
        check("mid_cmd_ready", 32'(cmd_ready), 1);
        $display("txn mid_reset: write aborted in WRESP, responses after reset=%0d", rsp_cnt - rsp_base);
        run_vec(vecs[0], 7);

        check("stable_while_valid", stab_err, 0);
        check("valid_drop_after_ready", proto_err, 0);
        check("rsp_single_pulse", pulse_err, 0);
        check("no_overlap", ovl_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
